// File: rtl/spi_target.sv
// SPI mode-0 responder giving an external master access to a small register file.
// Optional macro SPI_TARGET_AUTOINC_EN: step the address by one after every data byte.
module spi_target #(
    parameter int NREGS = 8
) (
    input  logic                   MHZ48,
    input  logic                   RES,
    input  logic                   nCS,
    input  logic                   SCLK,
    input  logic                   MOSI,
    output logic                   MISO,
    output logic                   MISO_OE,
    input  logic [7:0]             STAT,
    output logic [8*(NREGS-1)-1:0] REGOUT,
    output logic                   WRSTB,
    output logic [3:0]             WRADDR
);
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t     state;
    logic       ncs_s1, ncs_s2, ncs_s3;
    logic       sclk_s1, sclk_s2, sclk_s3;
    logic       mosi_s1, mosi_s2;
    logic       ncs_fall, ncs_rise, sclk_rise, sclk_fall;
    logic [2:0] bit_cnt;
    logic [6:0] shift_in;
    logic [6:0] shift_out;
    logic       is_read;
    logic [3:0] addr;
    logic       load_pending;
    logic [7:0] rx_byte;
    logic [7:0] rd_data;
    logic       addr_writable;
    logic [7:0] regs [1:NREGS-1];

    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            ncs_s1  <= 1'b1;
            ncs_s2  <= 1'b1;
            ncs_s3  <= 1'b1;
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            ncs_s1  <= nCS;
            ncs_s2  <= ncs_s1;
            ncs_s3  <= ncs_s2;
            sclk_s1 <= SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= MOSI;
            mosi_s2 <= mosi_s1;
        end
    end

    assign ncs_fall  = ncs_s3 & ~ncs_s2;
    assign ncs_rise  = ~ncs_s3 & ncs_s2;
    assign sclk_rise = ~sclk_s3 & sclk_s2;
    assign sclk_fall = sclk_s3 & ~sclk_s2;
    assign rx_byte   = {shift_in, mosi_s2};

    // Address 0 reads STAT, unimplemented addresses read all ones.
    always_comb begin
        rd_data       = 8'hFF;
        addr_writable = 1'b0;
        if (addr == 4'd0) rd_data = STAT;
        for (int i = 1; i < NREGS; i++) begin
            if (addr == 4'(i)) begin
                rd_data       = regs[i];
                addr_writable = 1'b1;
            end
        end
    end

    always_ff @(posedge MHZ48 or posedge RES) begin
        if (RES) begin
            state        <= IDLE;
            bit_cnt      <= 3'd0;
            shift_in     <= 7'd0;
            shift_out    <= 7'd0;
            is_read      <= 1'b0;
            addr         <= 4'd0;
            load_pending <= 1'b0;
            MISO         <= 1'b0;
            MISO_OE      <= 1'b0;
            WRSTB        <= 1'b0;
            WRADDR       <= 4'd0;
            for (int i = 1; i < NREGS; i++) regs[i] <= 8'h00;
        end else begin
            WRSTB <= 1'b0;
            if (ncs_rise) begin
                state        <= IDLE;
                MISO_OE      <= 1'b0;
                MISO         <= 1'b0;
                load_pending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ncs_fall) begin
                            state        <= CMD;
                            bit_cnt      <= 3'd0;
                            shift_out    <= STAT[6:0];
                            MISO         <= STAT[7];
                            MISO_OE      <= 1'b1;
                            load_pending <= 1'b0;
                        end
                    end
                    CMD, DATA: begin
                        if (sclk_rise) begin
                            shift_in <= rx_byte[6:0];
                            bit_cnt  <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                load_pending <= 1'b1;
                                if (state == CMD) begin
                                    state   <= DATA;
                                    is_read <= rx_byte[7];
                                    addr    <= rx_byte[3:0];
                                end else begin
                                    if (!is_read && addr_writable) begin
                                        for (int i = 1; i < NREGS; i++) begin
                                            if (addr == 4'(i)) regs[i] <= rx_byte;
                                        end
                                        WRSTB  <= 1'b1;
                                        WRADDR <= addr;
                                    end
`ifdef SPI_TARGET_AUTOINC_EN
                                    addr <= addr + 4'd1;
`endif
                                end
                            end
                        end else if (sclk_fall) begin
                            // First falling edge after a whole byte presents the next reply byte.
                            if (load_pending) begin
                                load_pending <= 1'b0;
                                shift_out    <= is_read ? rd_data[6:0] : 7'd0;
                                MISO         <= is_read ? rd_data[7] : 1'b0;
                            end else begin
                                shift_out <= {shift_out[5:0], 1'b0};
                                MISO      <= shift_out[6];
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar g = 1; g < NREGS; g++) begin : g_regout
        assign REGOUT[8*g-1 -: 8] = regs[g];
    end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: directed scenarios then random transactions,
// compared against a byte-level model of the register protocol.
module tb_spi_target;
    localparam int NREGS = 8;
    localparam int HALF  = 6;

    logic                   MHZ48;
    logic                   RES;
    logic                   nCS;
    logic                   SCLK;
    logic                   MOSI;
    logic                   MISO;
    logic                   MISO_OE;
    logic [7:0]             STAT;
    logic [8*(NREGS-1)-1:0] REGOUT;
    logic                   WRSTB;
    logic [3:0]             WRADDR;

    int         checks = 0;
    int         errors = 0;
    int         wideStb = 0;
    logic       prevStb = 1'b0;
    logic [3:0] strobeQ[$];
    int         expStrobe[$];
    logic [7:0] txBytes[8];
    logic [7:0] rxBytes[8];
    logic [7:0] expRx[8];
    logic [7:0] modelRegs[16];
    logic [7:0] dummy;

    spi_target #(.NREGS(NREGS)) dut (
        .MHZ48(MHZ48), .RES(RES), .nCS(nCS), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(MISO), .MISO_OE(MISO_OE), .STAT(STAT), .REGOUT(REGOUT),
        .WRSTB(WRSTB), .WRADDR(WRADDR)
    );

    initial MHZ48 = 1'b0;
    always #5 MHZ48 = ~MHZ48;

    // Record every strobe and flag any that lasts more than one cycle.
    always @(negedge MHZ48) begin
        if (WRSTB) strobeQ.push_back(WRADDR);
        if (WRSTB && prevStb) wideStb++;
        prevStb = WRSTB;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge MHZ48);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic spiByte(input logic [7:0] tx, input int nBits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 7; b > 7 - nBits; b--) begin
            MOSI = tx[b];
            waitCycles(HALF);
            rx[b] = MISO;
            SCLK = 1'b1;
            waitCycles(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic applyStimulus(input int nBytes, input int lastBits);
        nCS = 1'b0;
        waitCycles(HALF);
        checkOutput("oe_selected", MISO_OE, 1);
        for (int k = 0; k < nBytes; k++)
            spiByte(txBytes[k], (k == nBytes - 1) ? lastBits : 8, rxBytes[k]);
        waitCycles(HALF);
        nCS = 1'b1;
        waitCycles(HALF);
        checkOutput("oe_deselected", MISO_OE, 0);
    endtask

    // Byte-level protocol model: status during the command, then read or write bytes.
    task automatic runModel(input int nBytes, input int lastBits);
        int         complete;
        logic       isRead;
        logic [3:0] a;
        complete = (lastBits == 8) ? nBytes : nBytes - 1;
        expStrobe.delete();
        expRx[0] = STAT;
        isRead   = txBytes[0][7];
        a        = txBytes[0][3:0];
        for (int k = 1; k < complete; k++) begin
            if (isRead) begin
                if (a == 0) expRx[k] = STAT;
                else if (int'(a) < NREGS) expRx[k] = modelRegs[a];
                else expRx[k] = 8'hFF;
            end else begin
                expRx[k] = 8'h00;
                if (a != 0 && int'(a) < NREGS) begin
                    modelRegs[a] = txBytes[k];
                    expStrobe.push_back(int'(a));
                end
            end
`ifdef SPI_TARGET_AUTOINC_EN
            a = a + 4'd1;
`endif
        end
    endtask

    function automatic logic [63:0] packedModel();
        logic [63:0] p;
        p = '0;
        for (int i = 1; i < NREGS; i++) p[8*i-8 +: 8] = modelRegs[i];
        return p;
    endfunction

    task automatic doTransaction(input int nBytes, input int lastBits);
        int complete;
        complete = (lastBits == 8) ? nBytes : nBytes - 1;
        strobeQ.delete();
        runModel(nBytes, lastBits);
        applyStimulus(nBytes, lastBits);
        for (int k = 0; k < complete; k++)
            checkOutput($sformatf("miso_byte%0d", k), rxBytes[k], expRx[k]);
        checkOutput("strobe_count", strobeQ.size(), expStrobe.size());
        for (int k = 0; k < strobeQ.size() && k < expStrobe.size(); k++)
            checkOutput("strobe_addr", strobeQ[k], expStrobe[k]);
        checkOutput("regout", REGOUT, packedModel());
    endtask

    initial begin
        int burstStrobes;
        for (int i = 0; i < 16; i++) modelRegs[i] = 8'h00;
        RES  = 1'b1;
        nCS  = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        STAT = 8'h00;
        waitCycles(3);
        checkOutput("rst_miso", MISO, 0);
        checkOutput("rst_oe", MISO_OE, 0);
        checkOutput("rst_wrstb", WRSTB, 0);
        checkOutput("rst_wraddr", WRADDR, 0);
        checkOutput("rst_regout", REGOUT, 0);
        RES = 1'b0;
        waitCycles(4);

        $display("[TB] reset in the middle of a data byte");
        strobeQ.delete();
        STAT = 8'h3C;
        nCS  = 1'b0;
        waitCycles(HALF);
        spiByte(8'h01, 8, dummy);
        spiByte(8'hEE, 4, dummy);
        RES = 1'b1;
        waitCycles(2);
        nCS  = 1'b1;
        SCLK = 1'b0;
        waitCycles(2);
        RES = 1'b0;
        waitCycles(10);
        checkOutput("abort_rst_oe", MISO_OE, 0);
        checkOutput("abort_rst_strobes", strobeQ.size(), 0);
        checkOutput("abort_rst_regout", REGOUT, 0);

        $display("[TB] write 0xA5 to register 3");
        STAT = 8'h5C;
        txBytes[0] = 8'h03; txBytes[1] = 8'hA5;
        doTransaction(2, 8);
        checkOutput("wr_reg3", REGOUT[23:16], 8'hA5);
        checkOutput("wr_strobes", strobeQ.size(), 1);

        $display("[TB] read register 3 with status 0x5C");
        txBytes[0] = 8'h83; txBytes[1] = 8'h00;
        doTransaction(2, 8);
        checkOutput("rd_status", rxBytes[0], 8'h5C);
        checkOutput("rd_reg3", rxBytes[1], 8'hA5);

        $display("[TB] three-byte burst write from address 6");
        txBytes[0] = 8'h06; txBytes[1] = 8'h11; txBytes[2] = 8'h22; txBytes[3] = 8'h33;
        doTransaction(4, 8);
`ifdef SPI_TARGET_AUTOINC_EN
        burstStrobes = 2;
        checkOutput("burst_reg7", REGOUT[55:48], 8'h22);
`else
        burstStrobes = 3;
`endif
        checkOutput("burst_strobes", strobeQ.size(), burstStrobes);

        $display("[TB] abort after 5 bits, protected address writes");
        txBytes[0] = 8'h02; txBytes[1] = 8'h77;
        doTransaction(2, 5);
        checkOutput("abort_reg2", REGOUT[15:8], 8'h00);
        txBytes[0] = 8'h00; txBytes[1] = 8'hFF;
        doTransaction(2, 8);
        checkOutput("wr_addr0_strobes", strobeQ.size(), 0);
        txBytes[0] = 8'h8F; txBytes[1] = 8'h00;
        doTransaction(2, 8);
        checkOutput("rd_addr15", rxBytes[1], 8'hFF);

        $display("[TB] random transactions");
        for (int t = 0; t < 24; t++) begin
            int n;
            int lastBits;
            n        = $urandom_range(1, 4);
            lastBits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
            STAT     = 8'($urandom);
            for (int k = 0; k < n; k++) txBytes[k] = 8'($urandom);
            doTransaction(n, lastBits);
        end

        checkOutput("strobe_width", wideStb, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_target.md
# spi_target

SPI mode-0 responder that lets an external SPI master, such as the host's bit-banged SPI port on SCLK/MOSI/MISO, read and write a small register file inside the CPLD. It runs in the MHZ48 domain and oversamples nCS, SCLK and MOSI through synchronizers. It exposes the writable registers as parallel outputs plus a write strobe. Register 0 is a read-only status input, and the same status byte is shifted out during every command byte.

## Interface
- NREGS, 8: number of register addresses; legal range 2..16. Address 0 is status; addresses 1..NREGS-1 are read/write.
- MHZ48  input  1  master clock; all state is clocked on its rising edge.
- RES  input  1  asynchronous reset, active-high.
- nCS  input  1  chip select from the SPI master, active-low, asynchronous.
- SCLK  input  1  SPI clock, asynchronous. Idles low (mode 0).
- MOSI  input  1  serial data in, MSB first.
- MISO  output  1  serial data out, MSB first.
- MISO_OE  output  1  tri-state enable for the MISO pad; 1 while selected.
- STAT  input  8  status byte, read at address 0.
- REGOUT  output  8*(NREGS-1)  registers 1..NREGS-1, flattened; register n occupies bits [8n-1:8n-8].
- WRSTB  output  1  one-cycle pulse when a register is written.
- WRADDR  output  4  address of the most recent write; valid while WRSTB is high and held afterwards.

## Operation
- Synchronizers: nCS, SCLK and MOSI each pass through two flops. A third flop on nCS and SCLK provides edge detection.
  - An edge is detected when the second and third flops differ.
  - All actions below occur at the MHZ48 edge on which the edge is detected.
- Transaction format: command byte, then zero or more data bytes.
  - Command bit 7 = R (1 = read, 0 = write); bits 3:0 = start address; bits 6:4 are ignored.
- States:
  - IDLE → CMD on nCS falling: clear the bit counter, load the shift-out register with STAT, assert MISO_OE, drive STAT[7] on MISO.
  - CMD → DATA on the 8th SCLK rising edge: latch R and the address.
  - DATA: 8-bit cycles repeat until nCS rises.
  - Any state → IDLE on nCS rising: MISO_OE = 0; any partial byte is discarded.
- Shifting:
  - MOSI is sampled on each SCLK rising edge.
  - MISO advances on each SCLK falling edge.
  - The 3-bit bit counter wraps from 7 to 0.
- Read data:
  - On the first SCLK falling edge after a completed byte, the shift-out register loads the byte at the current address; its MSB appears on MISO.
  - Address 0 returns STAT, as sampled at load time.
  - Addresses NREGS..15 return 0xFF.
- Write data: on the 8th rising edge of a data byte:
  - If the address is in 1..NREGS-1: update the register, pulse WRSTB, set WRADDR.
  - Writes to address 0 or to addresses ≥ NREGS are dropped, with no strobe.
- During write transactions MISO shifts 0x00 for data bytes.
- Address step after each completed data byte depends on configuration (see Configuration).
- Reset: RES forces IDLE asynchronously.
  - Reset values: MISO = 0, MISO_OE = 0, WRSTB = 0, WRADDR = 0, all REGOUT = 0x00, synchronizer flops = idle levels (nCS = 1, SCLK = 0, MOSI = 0).
  - Reset mid-transaction aborts it without a strobe. After RES releases, a new nCS falling edge is required before any byte is accepted.
- Simultaneous events: if nCS rising and an SCLK edge are detected on the same cycle, nCS wins and the SCLK edge is ignored.

## Timing
- Detection latency: pin edge to action is 3 MHZ48 cycles, with up to +1 cycle of synchronizer uncertainty.
- SCLK high and low phases must each be ≥ 4 MHZ48 cycles, giving SCLK ≤ 6 MHz. Slower bit-banged clocks are unconstrained.
- nCS falling to first SCLK rising: ≥ 4 cycles.
- Last SCLK falling to nCS rising: ≥ 4 cycles.
- MISO is valid ≤ 4 cycles after each SCLK falling edge (or after nCS falling for the first bit), so it is stable before the next rising edge.
- WRSTB: exactly 1 cycle wide. It asserts in the same cycle REGOUT updates, i.e. 3 (+1) cycles after the 8th rising SCLK edge of the byte.
- Back-to-back writes produce one strobe per byte, ≥ 8 SCLK periods apart.

## Configuration
- SPI_TARGET_AUTOINC_EN defined:
  - The address increments by one after each completed data byte, wrapping 15 → 0.
  - Out-of-range addresses along the way behave as described in Operation.
- SPI_TARGET_AUTOINC_EN undefined:
  - The address stays fixed for the whole transaction.
  - Repeated reads re-sample the same register (useful for polling STAT); repeated writes re-write the same register, each with its own WRSTB.

## Test plan
- Reset: assert RES mid-byte, release, idle 10 cycles → MISO_OE = 0, WRSTB never pulses, all REGOUT = 0x00.
- Write: nCS low, send 0x03, 0xA5, nCS high → REGOUT reg3 = 0xA5, exactly one WRSTB with WRADDR = 3, other registers unchanged.
- Read with status: STAT = 0x5C; nCS low, send 0x83, 0x00 → MISO returns 0x5C during the command byte and 0xA5 during the data byte; MISO_OE high only while nCS is low.
- Burst (AUTOINC_EN): write 0x06, 0x11, 0x22, 0x33 with NREGS = 8 → reg6 = 0x11, reg7 = 0x22, the third byte (address 8) is dropped, exactly 2 WRSTB pulses.
  - Same stimulus without the macro → reg6 = 0x33, 3 WRSTB pulses, each with WRADDR = 6.
- Abort and protected addresses:
  - nCS rises after 5 bits of a data byte to reg2 → no WRSTB, reg2 unchanged.
  - Write 0x00, 0xFF → no strobe.
  - Read 0x8F → MISO data byte = 0xFF.
